uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receive-side frame decoder; the counterpart of the transmit path (serializer and parity calculator).
- Oversamples the serial line at PRESCALE clocks per bit and detects the start bit.
- Deserializes 8 data bits LSB-first, then checks the optional parity bit and the stop bit.
- Presents the byte with a one-cycle valid strobe and one-cycle error flags to the host-side logic.

Parameters:
- PRESCALE, 8, clocks per bit; even, >= 4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rx_in  input  1  serial line; idle high; already synchronized upstream
- par_en  input  1  1 = frame carries a parity bit
- par_typ  input  1  1 = odd parity, 0 = even parity (same encoding as the Tx parity calculator)
- p_data  output  DATA_WIDTH  last correctly received byte
- data_valid  output  1  one-cycle pulse: p_data updated with a good frame
- par_err  output  1  one-cycle pulse: parity mismatch
- stp_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; all counters are cleared.
  - p_data = 0; data_valid = par_err = stp_err = busy = 0.
  - Reset mid-frame abandons the frame; no strobes are produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_in sampled 0 on a clk edge -> START; edge_cnt = 0 counts that clock as tick 0.
  - par_en and par_typ are latched at this point and held for the whole frame.
- Bit timing:
  - edge_cnt runs 0..PRESCALE-1 within each bit; bit_cnt advances when edge_cnt wraps.
  - Sampled bit = majority of rx_in at ticks PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The sampled value is valid from tick PRESCALE/2+2 onward.
- START:
  - Sampled value 1 = glitch: go to IDLE at the end of the sample window. No strobes, no errors.
  - Sampled value 0: go to DATA when edge_cnt wraps.
- DATA:
  - DATA_WIDTH bits, LSB first, shifted into an internal shift register.
  - After the last data bit: go to PARITY if par_en, else STOP.
- PARITY:
  - expected = ^data when par_typ = 0; expected = ~^data when par_typ = 1.
  - Mismatch is recorded internally and reported only at frame end.
- STOP:
  - Sampled 0 records a stop error.
  - At the final tick (edge_cnt = PRESCALE-1) the frame completes; the next cycle is IDLE.
- Frame completion, in the cycle after the stop bit's final tick:
  - No errors: p_data <= shift register and data_valid = 1 for exactly one cycle.
  - Any error: p_data is unchanged and data_valid = 0. par_err and/or stp_err pulse for one cycle; both may assert together.
- Back-to-back frames:
  - A start bit beginning immediately after the stop bit must be detected.
  - IDLE samples rx_in in the same cycle that the strobes are issued.
- Frame length is (2 + DATA_WIDTH + par_en) x PRESCALE clocks.
- Changes to par_en or par_typ mid-frame have no effect until the next frame.
- Strobes are never asserted outside the frame-completion cycle.

Test Plan:
- PRESCALE=8, par_en=1, par_typ=0. Send 0xA5 with parity bit 0 and stop 1.
  -> data_valid pulses once, p_data = 0xA5, no errors, 88 clocks after start detect.
- par_typ=1. Send 0x3C with parity bit 1 (odd).
  -> p_data = 0x3C, data_valid for 1 cycle. Resend with parity bit 0 -> par_err pulse, data_valid = 0, p_data stays 0x3C.
- par_en=0. Send 0x81 with stop bit driven 0.
  -> stp_err pulses for 1 cycle, data_valid = 0, p_data unchanged. FSM returns to IDLE and busy falls.
- Glitch: rx_in low for 2 clocks, then high.
  -> FSM returns to IDLE within PRESCALE clocks, no strobes, busy high for under 8 cycles.
- Back-to-back frames 0x55 then 0xAA, no idle gap, par_en=0.
  -> two data_valid pulses exactly 80 clocks apart, p_data = 0x55 then 0xAA.
- Assert rst low midway through the DATA bits of a frame.
  -> all outputs 0 immediately. After release, a clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// UART receive-side frame decoder. The serial line is oversampled at
// PRESCALE clocks per bit. A low level seen in IDLE starts a frame. Each bit
// is decided by a 3-sample majority vote around the bit centre. Data is
// shifted in LSB first. The optional parity bit and the stop bit are
// checked, and the result is reported with one-cycle strobes.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx_in      serial line, idle high, already synchronized upstream
//   par_en     1 = frame carries a parity bit (latched at start detect)
//   par_typ    1 = odd parity, 0 = even parity (latched at start detect)
//   p_data     last correctly received byte
//   data_valid one-cycle pulse: p_data updated with a good frame
//   par_err    one-cycle pulse: parity mismatch in the completed frame
//   stp_err    one-cycle pulse: stop bit sampled low in the completed frame
//   busy       high while a frame is in progress (state != IDLE)
//
// Handshake: the outputs are push-only strobes with no ready. data_valid,
// par_err and stp_err are asserted for exactly the one cycle after the
// stop bit's last tick. p_data is valid whenever data_valid is high, and it
// holds its value until the next good frame.
module uart_rx_frame #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [EW-1:0] TICK_ONE  = EW'(1);
    localparam logic [EW-1:0] TICK_LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] SAMP_A    = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SAMP_B    = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] SAMP_C    = EW'(PRESCALE / 2 + 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [EW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [1:0]            samp;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  stp_bad;

    logic last_tick;
    logic samp_end;
    logic bit_val;
    logic par_exp;
    logic stp_bad_now;

    // The third vote is taken straight from rx_in. This lets the bit decision
    // be used on the closing tick of the sample window.
    always_comb begin
        last_tick   = (edge_cnt == TICK_LAST);
        samp_end    = (edge_cnt == SAMP_C);
        bit_val     = (samp[0] & samp[1]) | (samp[0] & rx_in) | (samp[1] & rx_in);
        par_exp     = par_typ_q ? ~(^shreg) : (^shreg);
        // When PRESCALE is 4, the stop sample and the final tick fall on the
        // same cycle. The completion decision therefore also includes the
        // stop vote being taken in this cycle.
        stp_bad_now = stp_bad | ((state == STOP) & samp_end & ~bit_val);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            stp_bad    <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= last_tick ? '0 : edge_cnt + TICK_ONE;
            end
            if (edge_cnt == SAMP_A) samp[0] <= rx_in;
            if (edge_cnt == SAMP_B) samp[1] <= rx_in;

            case (state)
                IDLE: begin
                    // The detecting clock is tick 0, so the count resumes at 1.
                    if (!rx_in) begin
                        state     <= START;
                        edge_cnt  <= TICK_ONE;
                        bit_cnt   <= '0;
                        par_en_q  <= par_en;
                        par_typ_q <= par_typ;
                        par_bad   <= 1'b0;
                        stp_bad   <= 1'b0;
                    end
                end
                START: begin
                    if (samp_end && bit_val) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (last_tick) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (samp_end) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                    if (last_tick) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (samp_end && (bit_val != par_exp)) par_bad <= 1'b1;
                    if (last_tick) state <= STOP;
                end
                STOP: begin
                    if (samp_end && !bit_val) stp_bad <= 1'b1;
                    if (last_tick) begin
                        state <= IDLE;
                        if (!par_bad && !stp_bad_now) begin
                            p_data     <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            par_err <= par_bad;
                            stp_err <= stp_bad_now;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
